// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a length/words/checksum byte image into instruction memory while holding the CPU in reset
module instr_mem_loader #(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_data,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR} state_t;
   localparam logic [16:0] CAP = 17'(2 ** ADDR_W);
   state_t state, state_nx;
   logic [15:0] len;
   logic [15:0] len_new;
   logic [31:0] word;
   logic [1:0] bcnt;
   logic [7:0] csum;
   logic [ADDR_W:0] wl_inc;
   logic acc, go, len_ok, last;
   assign rx_ready = state inside {LEN_LO, LEN_HI, DATA, CSUM};
   assign busy = rx_ready | (state == WRITE);
   assign acc = rx_valid & rx_ready;
   assign go = start & (state inside {IDLE, DONE, ERR});
   assign len_new = {rx_data, len[7:0]};
   assign len_ok = (len_new != 16'd0) && ({1'b0, len_new} <= CAP);
   assign wl_inc = words_loaded + 1'b1;
   assign last = 16'(wl_inc) == len;
   // write port outputs decode the state directly so an async reset kills a write at once
   assign mem_wren = state == WRITE;
   assign mem_addr = words_loaded[ADDR_W-1:0];
   assign mem_data = word;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE, ERR: state_nx = go ? LEN_LO : state;
         LEN_LO:          state_nx = acc ? LEN_HI : state;
         LEN_HI:          state_nx = acc ? (len_ok ? DATA : ERR) : state;
         DATA:            state_nx = (acc && bcnt == 2'd3) ? WRITE : state;
         WRITE:           state_nx = last ? CSUM : DATA;
         CSUM:            state_nx = acc ? ((rx_data == csum) ? DONE : ERR) : state;
         default:         state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rst_n <= 1'b0;
         len <= '0;
         word <= '0;
         bcnt <= '0;
         csum <= '0;
         done <= 1'b0;
         err <= 1'b0;
         words_loaded <= '0;
      end else begin
         cpu_rst_n <= (state == IDLE) || (state == DONE);
         if (go) begin
            words_loaded <= '0;
            bcnt <= '0;
            csum <= '0;
            done <= 1'b0;
            err <= 1'b0;
         end
         if (acc && state == LEN_LO) len[7:0] <= rx_data;
         if (acc && state == LEN_HI) begin
            len[15:8] <= rx_data;
            err <= !len_ok;
         end
         if (acc && state == DATA) begin
            word[{bcnt, 3'b000} +: 8] <= rx_data;
            bcnt <= bcnt + 2'd1;
            csum <= csum ^ rx_data;
         end
         if (state == WRITE) words_loaded <= wl_inc;
         if (acc && state == CSUM) begin
            done <= rx_data == csum;
            err <= rx_data != csum;
         end
      end
   end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized image loads checked by a write/result scoreboard against a byte-image model
module tb_instr_mem_loader;
   localparam int AW = 7;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx_valid = 1'b0;
   logic [7:0] rx_data = '0;
   logic rx_ready, mem_wren, cpu_rst_n, busy, done, err;
   logic [AW-1:0] mem_addr;
   logic [31:0] mem_data;
   logic [AW:0] words_loaded;
   int vecs = 0, errs = 0, cyc = 0;
   logic [AW+31:0] exp_w[$];
   logic [AW+2:0] exp_r[$];
   logic [7:0] img[$];
   logic [AW+31:0] w;
   logic [AW+2:0] r;
   logic prev_busy = 1'b0;

   instr_mem_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data),
      .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      vecs++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endfunction

   always @(negedge clk) begin
      if (rst_n && mem_wren) begin
         if (exp_w.size() == 0) begin
            vecs++; errs++;
            $display("FAIL unexpected write: got addr %0h data %0h expected none", mem_addr, mem_data);
         end else begin
            w = exp_w.pop_front();
            check("write addr", 64'(mem_addr), 64'(w[AW+31:32]));
            check("write data", 64'(mem_data), 64'(w[31:0]));
            check("rx_ready in write", 64'(rx_ready), 64'd0);
         end
      end
      if (rst_n && prev_busy && !busy) begin
         if (exp_r.size() == 0) begin
            vecs++; errs++;
            $display("FAIL unexpected completion: got done %0b err %0b expected none", done, err);
         end else begin
            r = exp_r.pop_front();
            check("done", 64'(done), 64'(r[AW+2]));
            check("err", 64'(err), 64'(r[AW+1]));
            check("words_loaded", 64'(words_loaded), 64'(r[AW:0]));
         end
      end
      prev_busy = busy;
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int n = 0;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      rx_data = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         vecs++; errs++;
         $display("FAIL rx_ready timeout: got 0 expected 1");
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic build(input int hdr, input int nw, input bit bad);
      logic [7:0] b, cs;
      cs = '0;
      img.delete();
      img.push_back(hdr[7:0]);
      img.push_back(hdr[15:8]);
      repeat (nw * 4) begin
         b = 8'($urandom);
         img.push_back(b);
         cs ^= b;
      end
      img.push_back(cs ^ (bad ? 8'h5A : 8'h00));
   endtask

   // model: header gives N; a legal N yields N little-endian words and a checksum verdict
   task automatic run_load(input int gmax, input bit mid);
      int n, cnt, c0;
      bit ok, legal;
      logic [7:0] cs;
      logic [31:0] w32;
      n = {img[1], img[0]};
      legal = n >= 1 && n <= 2 ** AW;
      ok = 1'b0;
      if (!legal) begin
         exp_r.push_back({1'b0, 1'b1, (AW + 1)'(0)});
         cnt = 2;
      end else begin
         cs = '0;
         for (int i = 0; i < n; i++) begin
            w32 = {img[4*i+5], img[4*i+4], img[4*i+3], img[4*i+2]};
            cs ^= w32[7:0] ^ w32[15:8] ^ w32[23:16] ^ w32[31:24];
            exp_w.push_back({AW'(i), w32});
         end
         ok = cs == img[4*n+2];
         exp_r.push_back({ok, !ok, (AW + 1)'(n)});
         cnt = 4 * n + 3;
      end
      pulse_start();
      c0 = cyc;
      for (int i = 0; i < cnt; i++) begin
         if (mid && i == 5) pulse_start();
         send(img[i], gmax > 0 ? int'($urandom_range(gmax, 0)) : 0);
         if (i == 0) begin
            check("cpu_rst_n held during load", 64'(cpu_rst_n), 64'd0);
            check("busy during load", 64'(busy), 64'd1);
         end
      end
      if (legal) begin
         if (gmax == 0 && !mid) check("load cycles", 64'(cyc - c0), 64'(3 + 5 * n));
         check("cpu_rst_n at completion", 64'(cpu_rst_n), 64'd0);
         @(negedge clk);
         check("cpu_rst_n after completion", 64'(cpu_rst_n), 64'(ok));
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [7:0] saved[$];
      logic [31:0] w32;
      repeat (2) @(negedge clk);
      check("reset cpu_rst_n", 64'(cpu_rst_n), 64'd0);
      rst_n = 1'b1;
      #1;
      check("reset rx_ready", 64'(rx_ready), 64'd0);
      check("reset mem_wren", 64'(mem_wren), 64'd0);
      check("reset mem_addr", 64'(mem_addr), 64'd0);
      check("reset mem_data", 64'(mem_data), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset err", 64'(err), 64'd0);
      check("reset words_loaded", 64'(words_loaded), 64'd0);
      check("cpu_rst_n before first edge", 64'(cpu_rst_n), 64'd0);
      @(negedge clk);
      check("cpu_rst_n after release", 64'(cpu_rst_n), 64'd1);

      img = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
      run_load(0, 1'b0);
      img[10] = 8'h00;
      run_load(0, 1'b0);
      build(0, 0, 1'b0);
      run_load(0, 1'b0);
      build(129, 0, 1'b0);
      run_load(0, 1'b0);
      build(128, 128, 1'b0);
      run_load(0, 1'b0);

      build(6, 6, 1'b0);
      saved = img;
      run_load(0, 1'b0);
      img = saved;
      run_load(3, 1'b1);
      for (int k = 0; k < 6; k++) begin
         build(int'($urandom_range(20, 1)), 0, 1'b0);
         build({img[1], img[0]}, {img[1], img[0]}, ($urandom_range(2, 0) == 0));
         run_load(2, k[0]);
      end

      build(3, 3, 1'b0);
      for (int i = 0; i < 2; i++) begin
         w32 = {img[4*i+5], img[4*i+4], img[4*i+3], img[4*i+2]};
         exp_w.push_back({AW'(i), w32});
      end
      pulse_start();
      for (int i = 0; i < 10; i++) send(img[i], 0);
      #2 rst_n = 1'b0;
      #1;
      check("mem_wren under reset", 64'(mem_wren), 64'd0);
      check("busy under reset", 64'(busy), 64'd0);
      check("words_loaded under reset", 64'(words_loaded), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rx_ready idle after reset", 64'(rx_ready), 64'd0);
      check("done after reset", 64'(done), 64'd0);
      check("err after reset", 64'(err), 64'd0);
      run_load(0, 1'b0);

      repeat (5) @(negedge clk);
      check("writes outstanding", 64'(exp_w.size()), 64'd0);
      check("results outstanding", 64'(exp_r.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
